// File: rtl/pixel_window_buffer.sv
// 3x3 sliding-window generator over a raster pixel stream using two line buffers.
// Optional macro PIXEL_WINDOW_FRAME_CNT_EN adds a 16-bit completed-frame counter output.
module pixel_window_buffer #(
    parameter int IMG_W = 8,
    parameter int IMG_H = 8,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     sof,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_pixel,
    output logic                     out_valid,
    output logic [9*PIX_W-1:0]       out_window,
    output logic [$clog2(IMG_H)-1:0] out_row,
    output logic [$clog2(IMG_W)-1:0] out_col,
    output logic                     frame_done
`ifdef PIXEL_WINDOW_FRAME_CNT_EN
    ,
    output logic [15:0]              frame_cnt
`endif
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    logic [CW-1:0]      r_col;
    logic [RW-1:0]      r_row;
    logic [CW-1:0]      w_col;
    logic [RW-1:0]      w_row;
    logic               w_emit;
    logic               w_last;
    logic [PIX_W-1:0]   w_top;
    logic [PIX_W-1:0]   w_mid;
    logic [9*PIX_W-1:0] w_win_next;

    logic [PIX_W-1:0]   r_lb1 [0:IMG_W-1];
    logic [PIX_W-1:0]   r_lb2 [0:IMG_W-1];
    logic [PIX_W-1:0]   r_win [0:2][0:2];

    // A qualified sof forces the current pixel to (0,0), aborting any frame in flight.
    always_comb begin
        w_col  = (sof && in_valid) ? '0 : r_col;
        w_row  = (sof && in_valid) ? '0 : r_row;
        w_top  = r_lb2[w_col];
        w_mid  = r_lb1[w_col];
        w_emit = in_valid && (w_row >= RW'(2)) && (w_col >= CW'(2));
        w_last = (w_row == ROW_LAST) && (w_col == COL_LAST);
    end

    always_comb begin
        w_win_next = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 2; c++) begin
                w_win_next[(3*r+c)*PIX_W +: PIX_W] = r_win[r][c+1];
            end
        end
        w_win_next[2*PIX_W +: PIX_W] = w_top;
        w_win_next[5*PIX_W +: PIX_W] = w_mid;
        w_win_next[8*PIX_W +: PIX_W] = in_pixel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col      <= '0;
            r_row      <= '0;
            out_valid  <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            if (in_valid) begin
                if (w_col == COL_LAST) begin
                    r_col <= '0;
                    r_row <= (w_row == ROW_LAST) ? '0 : w_row + 1'b1;
                end else begin
                    r_col <= w_col + 1'b1;
                    r_row <= w_row;
                end
            end
            out_valid  <= w_emit;
            frame_done <= w_emit && w_last;
            if (w_emit) begin
                out_window <= w_win_next;
                out_row    <= w_row;
                out_col    <= w_col;
            end
        end
    end

    // Line buffers and shift array are pure storage and are never reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_lb2[w_col] <= w_mid;
            r_lb1[w_col] <= in_pixel;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    r_win[r][c] <= w_win_next[(3*r+c)*PIX_W +: PIX_W];
                end
            end
        end
    end

`ifdef PIXEL_WINDOW_FRAME_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (frame_done) begin
            frame_cnt <= frame_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/pixel_window_buffer.md
Name: pixel_window_buffer

Overview:
- Downstream consumer of the pixel control stage's output pixel stream.
- Buffers raster-ordered pixels in two line buffers and emits a 3x3 neighbourhood window for every valid interior position.
- The window feeds the convolution / neuron stage of light_nn.
- No backpressure: the upstream stream is push-only and this block never stalls it.

Parameters:
- IMG_W, 8, pixels per row; legal range >= 3.
- IMG_H, 8, rows per frame; legal range >= 3.
- PIX_W, 8, bits per pixel.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sof  input  1  start of frame; qualified by in_valid; marks the accepted pixel as (row 0, col 0).
- in_valid  input  1  in_pixel is valid this cycle.
- in_pixel  input  PIX_W  raster-order pixel from the pixel control stage.
- out_valid  output  1  out_window, out_row and out_col are valid this cycle.
- out_window  output  9*PIX_W  3x3 window; element k=3r+c at bits [k*PIX_W +: PIX_W]; r=0 is the oldest row, c=0 the oldest column.
- out_row  output  $clog2(IMG_H)  row of the window's bottom-right pixel.
- out_col  output  $clog2(IMG_W)  column of the window's bottom-right pixel.
- frame_done  output  1  one-cycle pulse coincident with the last window of a complete frame.

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid, out_window, out_row, out_col, frame_done = 0.
  - Row/column counters = 0.
  - Line-buffer RAM contents are not reset.
- Accepted pixel = clk edge with in_valid=1.
- Counters:
  - col increments on each accepted pixel and wraps IMG_W-1 -> 0.
  - On that wrap, row increments and wraps IMG_H-1 -> 0.
- sof=1 with in_valid=1: the pixel is taken as (0,0) and counters restart from it.
  - Mid-frame sof aborts the current frame: no frame_done for it, and no stale window is emitted.
- sof with in_valid=0 is ignored.
- Line buffers: two IMG_W-deep buffers, addressed by col, holding rows row-1 and row-2.
  - Written in the same cycle as the read (read-before-write).
- Window register: 3x3 shift array.
  - Each accepted pixel shifts columns left.
  - New right column = {linebuf2[col], linebuf1[col], in_pixel}.
- Emission:
  - When the accepted pixel has row >= 2 and col >= 2, out_valid=1 on the next cycle (latency 1).
  - out_row/out_col carry that pixel's row/col; element 8 equals that pixel.
- Otherwise out_valid=0 the next cycle, and out_window holds its last value.
- No wrap-around windows: for col 0..1 of any row, out_valid stays 0 even though the shift array holds previous-row pixels.
- in_valid gaps: all state frozen; out_valid=0 during the gap; output is cycle-count independent.
- Windows per frame = (IMG_W-2)*(IMG_H-2).
- frame_done=1 together with out_valid for the pixel at (IMG_H-1, IMG_W-1).
- Back-to-back frames with zero idle cycles are supported.
- Reset asserted mid-frame: everything clears immediately.
  - After release, the first accepted pixel is (0,0) whether or not sof is asserted.

Optional Feature:
- Macro: PIXEL_WINDOW_FRAME_CNT_EN.
- Defined:
  - Adds output port frame_cnt, 16 bits, reset 0.
  - Increments on the cycle frame_done is high; wraps 65535 -> 0.
  - Aborted frames are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- IMG_W=IMG_H=4, sof on first pixel, pixels 0..15 continuous (value = 4*row+col) -> exactly 4 windows:
  - 1st: {0,1,2,4,5,6,8,9,10}, row2/col2, 1 cycle after pixel 10.
  - Last: {5,6,7,9,10,11,13,14,15}, row3/col3, with frame_done=1.
- Same frame with in_valid toggling 1/0 every cycle -> identical window contents and order; out_valid never high on consecutive cycles.
- Two back-to-back frames, second frame values +100 -> second frame's first window is {100,101,102,104,105,106,108,109,110}; no window mixes frames; two frame_done pulses.
- sof reasserted at pixel 9 of frame 1 -> no frame_done for the aborted frame; the next window appears only after the new frame reaches (2,2).
- rst_n pulsed low asynchronously (mid-cycle) at pixel 11 -> all outputs 0 immediately; the next frame, started without sof, matches the first scenario's windows.
- With PIXEL_WINDOW_FRAME_CNT_EN: three complete frames plus one aborted frame -> frame_cnt = 3.
